id_ex_hazard_reg: RTL and testbench
===================================

Name: id_ex_hazard_reg

Overview:
- ID/EX pipeline register of the stalling 5-stage MIPS core, with load/RAW hazard detection.
- Sits directly downstream of the register file. Latches its two read operands plus decoded control into the EX stage.
- Inserts bubbles and asserts a stall toward PC/IF-ID while a source register has a pending write in EX or MEM.
- No forwarding. WB-stage writes are already visible because the register file writes on the falling edge.

Parameters:
- CTRL_W, 16, width of the opaque decoded-control bundle passed ID->EX.

Ports:
- clk  in  1  clock, rising-edge active
- rst  in  1  synchronous active-high reset
- id_valid  in  1  ID stage holds a real instruction
- id_rs  in  5  source register 1 (register file n1)
- id_rt  in  5  source register 2 (register file n2)
- id_uses_rs  in  1  instruction reads rs
- id_uses_rt  in  1  instruction reads rt
- id_op1  in  32  register file read data for rs
- id_op2  in  32  register file read data for rt
- id_imm  in  32  sign/zero-extended immediate
- id_wreg  in  1  instruction writes a register
- id_dest  in  5  destination register number
- id_ctrl  in  CTRL_W  decoded control bundle
- mem_wreg  in  1  EX/MEM instruction writes a register
- mem_dest  in  5  EX/MEM destination register
- flush  in  1  branch/jump redirect: squash the ID instruction
- stall  out  1  freeze PC and IF/ID this cycle
- ex_valid  out  1  EX holds a real instruction
- ex_op1  out  32  registered operand 1
- ex_op2  out  32  registered operand 2
- ex_imm  out  32  registered immediate
- ex_wreg  out  1  registered write enable
- ex_dest  out  5  registered destination
- ex_ctrl  out  CTRL_W  registered control bundle
- stall_cnt  out  32  stall-cycle counter (see Optional Feature)

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high. Sampled only at posedge clk.
- On rst, all ex_* outputs and stall_cnt are 0 at the next edge. rst has priority over flush and hazard.
- Match terms, all combinational:
  - match_ex(r) = (r != 0) & ex_valid & ex_wreg & (ex_dest == r)
  - match_mem(r) = (r != 0) & mem_wreg & (mem_dest == r)
- hazard = id_valid & ((id_uses_rs & (match_ex(id_rs) | match_mem(id_rs))) | (id_uses_rt & (match_ex(id_rt) | match_mem(id_rt)))).
- stall = hazard & ~flush & ~rst. It is combinational and has no registered latency.
- Register 0 never causes a hazard.
- Per rising edge, in priority order:
  - rst: clear all outputs.
  - flush: insert a bubble.
  - hazard: insert a bubble.
  - otherwise: load ex_* from id_*, with ex_valid = id_valid.
- Bubble: ex_valid = 0, ex_wreg = 0, ex_dest = 0, ex_ctrl = 0, operands and imm = 0. A bubble never writes.
- Invalid ID (id_valid = 0, no flush): ex_valid = 0 and ex_wreg is forced to 0.
- Stall length:
  - producer one stage ahead (in EX): 2 cycles;
  - producer two ahead (in MEM): 1 cycle;
  - producer in WB: 0 cycles.
- While stalled, ID inputs are held by upstream. This block re-reads id_op1/id_op2 every cycle, so the post-writeback value is latched on release.
- Flush and hazard in the same cycle: bubble, stall = 0, and the instruction is discarded.
- Reset mid-stall: stall drops in the reset cycle. After reset, EX and MEM are empty, so no stale hazard persists.

Optional Feature:
- Macro: STALL_CNT_EN.
- Defined: stall_cnt is a 32-bit counter.
  - Increments on each edge where stall = 1.
  - Saturates at 32'hFFFF_FFFF.
  - Cleared by rst.
- Undefined: no counter flop; stall_cnt is tied to 0. The port remains so the top level is unchanged.

Test Plan:
- Reset: assert rst for 2 cycles with random inputs -> all ex_* = 0, stall = 0, stall_cnt = 0.
- EX-producer RAW: EX holds wreg = 1, dest = 5. ID reads rs = 5 (uses_rs = 1) -> stall = 1 for 2 cycles with bubbles in EX. On the 3rd edge ex_op1 = the new $5 value (e.g. 32'h0000_00AA) and ex_valid = 1.
- MEM-producer RAW on rt: mem_wreg = 1, mem_dest = 9; ID has rt = 9, uses_rt = 1 -> exactly 1 stall cycle, then normal latch.
- Zero/unused sources: ex_dest = 0 with wreg = 1 and id_rs = 0 -> no stall. rt = 5 matches EX dest but uses_rt = 0 -> no stall.
- Flush priority: hazard present and flush = 1 -> stall = 0, ex_valid = 0, ex_wreg = 0 next edge.
- STALL_CNT_EN: run the EX-RAW plus MEM-RAW scenarios -> stall_cnt = 3. Without the macro, stall_cnt stays 0.

Source files
------------

// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load/RAW hazard detection for the stalling 5-stage core.
// Optional stall-cycle counter is enabled by defining STALL_CNT_EN.
module id_ex_hazard_reg #(
   parameter int CTRL_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [4:0]        id_rs,
   input  logic [4:0]        id_rt,
   input  logic              id_uses_rs,
   input  logic              id_uses_rt,
   input  logic [31:0]       id_op1,
   input  logic [31:0]       id_op2,
   input  logic [31:0]       id_imm,
   input  logic              id_wreg,
   input  logic [4:0]        id_dest,
   input  logic [CTRL_W-1:0] id_ctrl,
   input  logic              mem_wreg,
   input  logic [4:0]        mem_dest,
   input  logic              flush,
   output logic              stall,
   output logic              ex_valid,
   output logic [31:0]       ex_op1,
   output logic [31:0]       ex_op2,
   output logic [31:0]       ex_imm,
   output logic              ex_wreg,
   output logic [4:0]        ex_dest,
   output logic [CTRL_W-1:0] ex_ctrl,
   output logic [31:0]       stall_cnt
);

   logic rs_ex_match;
   logic rs_mem_match;
   logic rt_ex_match;
   logic rt_mem_match;
   logic hazard;

   // A pending write in EX or MEM blocks the reader; WB writes land on the
   // falling edge, so the register file already returns them.
   always_comb begin
      rs_ex_match  = (id_rs != 5'd0) & ex_valid & ex_wreg & (ex_dest == id_rs);
      rs_mem_match = (id_rs != 5'd0) & mem_wreg & (mem_dest == id_rs);
      rt_ex_match  = (id_rt != 5'd0) & ex_valid & ex_wreg & (ex_dest == id_rt);
      rt_mem_match = (id_rt != 5'd0) & mem_wreg & (mem_dest == id_rt);
      hazard = id_valid &
               ((id_uses_rs & (rs_ex_match | rs_mem_match)) |
                (id_uses_rt & (rt_ex_match | rt_mem_match)));
   end

   assign stall = hazard & ~flush & ~rst;

   // ex_valid qualifies every ex_* field; an invalid slot never writes (ex_wreg = 0).
   always_ff @(posedge clk) begin
      if (rst || flush || hazard) begin
         ex_valid <= 1'b0;
         ex_op1   <= 32'd0;
         ex_op2   <= 32'd0;
         ex_imm   <= 32'd0;
         ex_wreg  <= 1'b0;
         ex_dest  <= 5'd0;
         ex_ctrl  <= '0;
      end else begin
         ex_valid <= id_valid;
         ex_op1   <= id_op1;
         ex_op2   <= id_op2;
         ex_imm   <= id_imm;
         ex_wreg  <= id_valid & id_wreg;
         ex_dest  <= id_dest;
         ex_ctrl  <= id_ctrl;
      end
   end

`ifdef STALL_CNT_EN
   logic [31:0] cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= 32'd0;
      end else if (stall && (cnt_q != 32'hFFFF_FFFF)) begin
         cnt_q <= cnt_q + 32'd1;
      end
   end

   assign stall_cnt = cnt_q;
`else
   assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// Self-checking bench for id_ex_hazard_reg: directed hazard scenarios plus a
// randomized run against a pending-writer-set reference model.
module tb_id_ex_hazard_reg;

   localparam int CTRL_W = 16;

   logic              clk;
   logic              rst;
   logic              id_valid;
   logic [4:0]        id_rs;
   logic [4:0]        id_rt;
   logic              id_uses_rs;
   logic              id_uses_rt;
   logic [31:0]       id_op1;
   logic [31:0]       id_op2;
   logic [31:0]       id_imm;
   logic              id_wreg;
   logic [4:0]        id_dest;
   logic [CTRL_W-1:0] id_ctrl;
   logic              mem_wreg;
   logic [4:0]        mem_dest;
   logic              flush;
   logic              stall;
   logic              ex_valid;
   logic [31:0]       ex_op1;
   logic [31:0]       ex_op2;
   logic [31:0]       ex_imm;
   logic              ex_wreg;
   logic [4:0]        ex_dest;
   logic [CTRL_W-1:0] ex_ctrl;
   logic [31:0]       stall_cnt;

   id_ex_hazard_reg #(.CTRL_W(CTRL_W)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_op1(id_op1),
      .id_op2(id_op2), .id_imm(id_imm), .id_wreg(id_wreg), .id_dest(id_dest),
      .id_ctrl(id_ctrl), .mem_wreg(mem_wreg), .mem_dest(mem_dest), .flush(flush),
      .stall(stall), .ex_valid(ex_valid), .ex_op1(ex_op1), .ex_op2(ex_op2),
      .ex_imm(ex_imm), .ex_wreg(ex_wreg), .ex_dest(ex_dest), .ex_ctrl(ex_ctrl),
      .stall_cnt(stall_cnt)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests_run = 0;
   int failures  = 0;

   // reference model: contents of the EX slot and the stall counter
   logic              m_valid;
   logic              m_wreg;
   logic [4:0]        m_dest;
   logic [31:0]       m_op1;
   logic [31:0]       m_op2;
   logic [31:0]       m_imm;
   logic [CTRL_W-1:0] m_ctrl;
   logic [31:0]       m_cnt;
   bit                last_stall;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock cycle with the currently driven inputs. With pipe_mem set, the
   // MEM stage receives what the model says EX held, as the real pipeline would.
   task automatic step(input bit pipe_mem);
      logic [31:0] pending;
      bit          haz;
      bit          exp_stall;
      if (pipe_mem) begin
         mem_wreg = m_valid & m_wreg;
         mem_dest = m_dest;
      end
      #1;
      pending = 32'd0;
      if (m_valid && m_wreg) pending[m_dest] = 1'b1;
      if (mem_wreg) pending[mem_dest] = 1'b1;
      pending[0] = 1'b0;
      haz = id_valid && ((id_uses_rs && pending[id_rs]) || (id_uses_rt && pending[id_rt]));
      exp_stall = haz && !flush && !rst;
      check("stall", {63'd0, stall}, {63'd0, exp_stall});
      @(posedge clk);
      if (rst || flush || haz) begin
         m_valid = 0; m_wreg = 0; m_dest = 0; m_op1 = 0; m_op2 = 0; m_imm = 0; m_ctrl = 0;
      end else begin
         m_valid = id_valid;
         m_wreg  = id_valid && id_wreg;
         m_dest  = id_dest;
         m_op1   = id_op1;
         m_op2   = id_op2;
         m_imm   = id_imm;
         m_ctrl  = id_ctrl;
      end
`ifdef STALL_CNT_EN
      if (rst) m_cnt = 32'd0;
      else if (exp_stall && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
`else
      m_cnt = 32'd0;
`endif
      last_stall = exp_stall;
      #1;
      check("ex_valid", {63'd0, ex_valid}, {63'd0, m_valid});
      check("ex_wreg", {63'd0, ex_wreg}, {63'd0, m_wreg});
      check("ex_dest", {59'd0, ex_dest}, {59'd0, m_dest});
      check("ex_op1", {32'd0, ex_op1}, {32'd0, m_op1});
      check("ex_op2", {32'd0, ex_op2}, {32'd0, m_op2});
      check("ex_imm", {32'd0, ex_imm}, {32'd0, m_imm});
      check("ex_ctrl", {48'd0, ex_ctrl}, {48'd0, m_ctrl});
      check("stall_cnt", {32'd0, stall_cnt}, {32'd0, m_cnt});
      @(negedge clk);
   endtask

   task automatic drive_id(input bit v, input logic [4:0] rs, input logic [4:0] rt,
                           input bit urs, input bit urt, input bit w, input logic [4:0] d);
      id_valid = v; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
      id_wreg = w; id_dest = d;
      id_op1 = $urandom; id_op2 = $urandom; id_imm = $urandom;
      id_ctrl = CTRL_W'($urandom);
   endtask

   task automatic rand_id();
      drive_id(($urandom_range(0, 7) != 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom_range(0, 7)));
   endtask

   initial begin
      m_valid = 0; m_wreg = 0; m_dest = 0; m_op1 = 0; m_op2 = 0; m_imm = 0; m_ctrl = 0;
      m_cnt = 0; last_stall = 0;
      rst = 1'b1; flush = 1'b0; mem_wreg = 1'b0; mem_dest = 5'd0;
      drive_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
      @(negedge clk);

      // reset with random inputs
      for (int i = 0; i < 2; i++) begin
         rand_id();
         mem_wreg = 1'($urandom); mem_dest = 5'($urandom_range(0, 31)); flush = 1'($urandom);
         step(1'b0);
      end
      rst = 1'b0; flush = 1'b0; mem_wreg = 1'b0; mem_dest = 5'd0;

      // EX-producer RAW: producer writes $5, consumer reads rs=5
      drive_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5);
      step(1'b1);
      drive_id(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd7);
      id_op1 = 32'h0000_00AA;
      for (int i = 0; i < 3; i++) step(1'b1);
      check("exraw_op1", {32'd0, ex_op1}, 64'h0000_00AA);
      check("exraw_valid", {63'd0, ex_valid}, 64'd1);

      // MEM-producer RAW on rt
      drive_id(1'b1, 5'd0, 5'd9, 1'b0, 1'b1, 1'b1, 5'd3);
      mem_wreg = 1'b1; mem_dest = 5'd9;
      step(1'b0);
      check("memraw_stall", {63'd0, last_stall}, 64'd1);
      step(1'b1);
      check("memraw_release", {63'd0, ex_valid}, 64'd1);
      check("stall_cnt_after_raw", {32'd0, stall_cnt},
`ifdef STALL_CNT_EN
            64'd3);
`else
            64'd0);
`endif

      // zero / unused sources: put a wreg=1 dest=0 producer, then a dest=5 producer
      drive_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0);
      step(1'b1);
      drive_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5);
      step(1'b1);
      drive_id(1'b1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 5'd1);
      step(1'b1);

      // flush priority over a live hazard
      drive_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd4);
      step(1'b1);
      drive_id(1'b1, 5'd4, 5'd0, 1'b1, 1'b0, 1'b1, 5'd6);
      flush = 1'b1;
      step(1'b1);
      flush = 1'b0;

      // randomized run
      for (int i = 0; i < 400; i++) begin
         rst   = ($urandom_range(0, 39) == 0);
         flush = ($urandom_range(0, 7) == 0);
         if (last_stall) begin
            id_op1 = $urandom; id_op2 = $urandom;
         end else begin
            rand_id();
         end
         if ($urandom_range(0, 3) == 0) begin
            mem_wreg = 1'($urandom); mem_dest = 5'($urandom_range(0, 7));
            step(1'b0);
         end else begin
            step(1'b1);
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, failures);
      $finish;
   end

endmodule
